// File: rtl/flp_to_int_wrapper.sv
// +--------------------------------------------------------------------------+
// | Module      : flp_to_int_wrapper                                         |
// | Description : Streams FFT BRAM coefficients, scales the real part by a   |
// |               power of two, rounds it and reduces it into [0, q-1].      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module flp_to_int_wrapper #(
   parameter int LOGN          = 13,
   parameter int LOGQ          = 54,
   parameter int W             = 24,
   parameter int M             = 17,
   parameter int EXPONENT_BITS = 11,
   parameter int MANTISSA_BITS = 52,
   parameter int OVERALL_BITS  = 1 + EXPONENT_BITS + MANTISSA_BITS
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic [3:0]                      current_k,
   input  logic [M-1:0]                    q_m,
   input  logic signed [EXPONENT_BITS:0]   scale_power,
   output logic [LOGN-1:0]                 bram_rd_addr,
   input  logic [2*OVERALL_BITS-1:0]       bram_rd_data,
   output logic [LOGN-1:0]                 bram_wr_addr,
   output logic [LOGQ-1:0]                 bram_wr_data,
   output logic                            bram_wea,
   output logic                            busy,
   output logic                            done,
   output logic                            overflow
);

   localparam int c_BIAS   = 2**(EXPONENT_BITS-1) - 1;
   localparam int c_EW     = EXPONENT_BITS + 3;
   localparam int c_MW     = LOGQ + 2;
   localparam int c_SHW    = c_MW + MANTISSA_BITS + 1;
   localparam int c_QRAW_W = 13 + M + W;

   localparam logic [LOGN-1:0]        c_LAST   = '1;
   localparam logic [c_EW-1:0]        c_BIAS_V = c_EW'(c_BIAS);
   localparam logic signed [c_EW-1:0] c_E_MAX  = c_EW'(LOGQ);
   localparam logic signed [c_EW-1:0] c_E_MIN  = '1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [LOGN-1:0]     r_rd_addr;
   logic [LOGN-1:0]     w_rd_addr_nxt;
   logic                w_start_acc;

   // Address/valid travel alongside the 2-cycle BRAM read.
   logic                r_rv_a, r_rv_b;
   logic [LOGN-1:0]     r_ra_a, r_ra_b;

   logic                r_s1_valid, r_s1_sign, r_s1_zero;
   logic [LOGN-1:0]     r_s1_addr;
   logic [MANTISSA_BITS-1:0] r_s1_mant;
   logic signed [c_EW-1:0]   r_s1_exp;

   logic                r_s2_valid, r_s2_sign, r_s2_big;
   logic [LOGN-1:0]     r_s2_addr;
   logic [c_MW-1:0]     r_s2_mag;

   logic                r_wea;
   logic [LOGN-1:0]     r_wr_addr;
   logic [LOGQ-1:0]     r_wr_data;
   logic                r_ovf;

   // ---------------------------------------------------------------- modulus
   logic [3:0]          w_k_shift;
   logic [12:0]         w_q_top;
   logic [c_QRAW_W-1:0] w_q_raw;
   logic [LOGQ:0]       w_q;

   assign w_k_shift = (current_k >= 4'd8) ? 4'd0 : (4'd8 - current_k);
   assign w_q_top   = 13'h1fff >> w_k_shift;
   assign w_q_raw   = {w_q_top, q_m, {(W-1){1'b0}}, 1'b1};
   assign w_q       = (LOGQ+1)'(w_q_raw);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_rd_addr <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_rd_addr <= w_rd_addr_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_rd_addr_nxt = r_rd_addr;
      w_start_acc   = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               w_state_nxt   = ST_READ;
               w_rd_addr_nxt = '0;
               w_start_acc   = 1'b1;
            end
         end
         ST_READ: begin
            if (r_rd_addr == c_LAST) begin
               w_state_nxt = ST_DRAIN;
            end else begin
               w_rd_addr_nxt = r_rd_addr + LOGN'(1);
            end
         end
         ST_DRAIN: begin
            if (r_wea && (r_wr_addr == c_LAST)) begin
               w_state_nxt = ST_DONE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- stage 1
   logic [OVERALL_BITS-1:0]  w_real;
   logic [EXPONENT_BITS-1:0] w_e;
   logic [c_EW-1:0]          w_exp;

   assign w_real = bram_rd_data[2*OVERALL_BITS-1 -: OVERALL_BITS];
   assign w_e    = w_real[MANTISSA_BITS +: EXPONENT_BITS];
   assign w_exp  = {3'b000, w_e} - c_BIAS_V
                 + {{2{scale_power[EXPONENT_BITS]}}, scale_power};

   // ---------------------------------------------------------------- stage 2
   logic                w_too_big, w_too_small;
   logic [c_EW-1:0]     w_shamt;
   logic [c_SHW-1:0]    w_sig_wide, w_shifted;
   logic [c_MW-1:0]     w_mag_g;

   // Shifting by E+1 keeps one fractional bit below the integer part.
   assign w_too_big   = (r_s1_exp >= c_E_MAX);
   assign w_too_small = (r_s1_exp <  c_E_MIN);
   assign w_shamt     = r_s1_exp + c_EW'(1);
   assign w_sig_wide  = c_SHW'({1'b1, r_s1_mant});
   assign w_shifted   = (w_sig_wide << w_shamt) >> MANTISSA_BITS;
   assign w_mag_g     = (r_s1_zero || w_too_small || w_too_big) ? '0 : w_shifted[c_MW-1:0];

   // ---------------------------------------------------------------- stage 3
   logic [LOGQ:0]       w_round, w_res;
   logic                w_ovf;

   assign w_round = r_s2_mag[c_MW-1:1] + (LOGQ+1)'(r_s2_mag[0]);
   assign w_ovf   = r_s2_big || (w_round >= w_q);

   always_comb begin
      w_res = w_round;
      if (w_ovf) begin
         w_res = '0;
      end else if (r_s2_sign && (w_round != '0)) begin
         w_res = w_q - w_round;
      end
   end

   logic w_unused;
   assign w_unused = ^{bram_rd_data[OVERALL_BITS-1:0], w_shifted[c_SHW-1:c_MW], w_res[LOGQ]};

   // ---------------------------------------------------------------- pipeline
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rv_a     <= 1'b0;
         r_rv_b     <= 1'b0;
         r_ra_a     <= '0;
         r_ra_b     <= '0;
         r_s1_valid <= 1'b0;
         r_s1_sign  <= 1'b0;
         r_s1_zero  <= 1'b0;
         r_s1_addr  <= '0;
         r_s1_mant  <= '0;
         r_s1_exp   <= '0;
         r_s2_valid <= 1'b0;
         r_s2_sign  <= 1'b0;
         r_s2_big   <= 1'b0;
         r_s2_addr  <= '0;
         r_s2_mag   <= '0;
         r_wea      <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_ovf      <= 1'b0;
      end else begin
         r_rv_a     <= (r_state == ST_READ);
         r_ra_a     <= r_rd_addr;
         r_rv_b     <= r_rv_a;
         r_ra_b     <= r_ra_a;

         r_s1_valid <= r_rv_b;
         r_s1_addr  <= r_ra_b;
         r_s1_sign  <= w_real[OVERALL_BITS-1];
         r_s1_zero  <= (w_e == '0);
         r_s1_mant  <= w_real[MANTISSA_BITS-1:0];
         r_s1_exp   <= w_exp;

         r_s2_valid <= r_s1_valid;
         r_s2_addr  <= r_s1_addr;
         r_s2_sign  <= r_s1_sign;
         r_s2_big   <= w_too_big && !r_s1_zero;
         r_s2_mag   <= w_mag_g;

         r_wea      <= r_s2_valid;
         if (r_s2_valid) begin
            r_wr_addr <= r_s2_addr;
            r_wr_data <= w_res[LOGQ-1:0];
         end

         if (w_start_acc) begin
            r_ovf <= 1'b0;
         end else if (r_s2_valid && w_ovf) begin
            r_ovf <= 1'b1;
         end
      end
   end

   assign bram_rd_addr = r_rd_addr;
   assign bram_wr_addr = r_wr_addr;
   assign bram_wr_data = r_wr_data;
   assign bram_wea     = r_wea;
   assign overflow     = r_ovf;
   assign busy         = (r_state == ST_READ) || (r_state == ST_DRAIN);
   assign done         = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_flp_to_int_wrapper.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_flp_to_int_wrapper                                      |
// | Description : Directed self-checking bench for flp_to_int_wrapper.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_flp_to_int_wrapper;

   localparam int N = 8192;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic [3:0]          current_k;
   logic [16:0]         q_m;
   logic signed [11:0]  scale_power;
   logic [12:0]         bram_rd_addr;
   logic [127:0]        bram_rd_data;
   logic [12:0]         bram_wr_addr;
   logic [53:0]         bram_wr_data;
   logic                bram_wea, busy, done, overflow;

   int                  pass_id;
   int                  checks = 0;
   int                  errors = 0;
   logic [127:0]        r_d1;

   always #5 clk = ~clk;

   flp_to_int_wrapper dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .current_k    (current_k),
      .q_m          (q_m),
      .scale_power  (scale_power),
      .bram_rd_addr (bram_rd_addr),
      .bram_rd_data (bram_rd_data),
      .bram_wr_addr (bram_wr_addr),
      .bram_wr_data (bram_wr_data),
      .bram_wea     (bram_wea),
      .busy         (busy),
      .done         (done),
      .overflow     (overflow)
   );

   // Hand-computed vectors: FP word, sign, rounded magnitude, overflow expected.
   function automatic void tv(input int p, input int i, output logic [63:0] fp,
                              output logic neg, output logic [63:0] mag, output logic ovf);
      fp = 64'h0; neg = 1'b0; mag = 64'd0; ovf = 1'b0;
      if (p == 1) begin
         case (i)
            0:  begin fp = 64'h4008000000000000; mag = 64'd3; end
            1:  begin fp = 64'hBFF0000000000000; neg = 1'b1; mag = 64'd1; end
            2:  begin fp = 64'h4004000000000000; mag = 64'd3; end
            3:  begin fp = 64'hC004000000000000; neg = 1'b1; mag = 64'd3; end
            4:  begin fp = 64'h3FDF5C28F5C28F5C; mag = 64'd0; end
            5:  begin fp = 64'h8000000000000000; neg = 1'b1; mag = 64'd0; end
            6:  begin fp = 64'h0000000000000000; mag = 64'd0; end
            7:  begin fp = 64'h3FE0000000000000; mag = 64'd1; end
            8:  begin fp = 64'hBFE0000000000000; neg = 1'b1; mag = 64'd1; end
            9:  begin fp = 64'h434FFFFFFFFFFFFF; ovf = 1'b1; end
            10: begin fp = 64'h408F420000000000; mag = 64'd1000; end
            11: begin fp = 64'hC01E000000000000; neg = 1'b1; mag = 64'd8; end
            12: begin fp = 64'h4340000000000000; mag = 64'd9007199254740992; end
            13: begin fp = 64'hBFDF5C28F5C28F5C; neg = 1'b1; mag = 64'd0; end
            14: begin fp = 64'h43B0000000000000; ovf = 1'b1; end
            default: begin fp = 64'h4350000000000000; ovf = 1'b1; end
         endcase
      end else if (p == 2) begin
         case (i)
            0:  begin fp = 64'h3FF8000000000000; mag = 64'd24; end
            1:  begin fp = 64'hBFF8000000000000; neg = 1'b1; mag = 64'd24; end
            2:  begin fp = 64'h42F0000000000000; ovf = 1'b1; end
            3:  begin fp = 64'h3FA0000000000000; mag = 64'd1; end
            default: begin fp = 64'h3FF0000000000000; mag = 64'd16; end
         endcase
      end else begin
         case (i)
            0:  begin fp = 64'h4058000000000000; mag = 64'd3; end
            1:  begin fp = 64'hC058000000000000; neg = 1'b1; mag = 64'd3; end
            2:  begin fp = 64'h4054000000000000; mag = 64'd3; end
            3:  begin fp = 64'h4030000000000000; mag = 64'd1; end
            default: begin fp = 64'h4008000000000000; mag = 64'd0; end
         endcase
      end
   endfunction

   function automatic logic [127:0] bram_word(input int p, input logic [12:0] a);
      logic [63:0] fp, mg;
      logic        n, o;
      tv(p, int'(a[3:0]), fp, n, mg, o);
      return {fp, 64'hDEADBEEF0BADF00D ^ {51'd0, a}};
   endfunction

   function automatic logic [54:0] calc_q(input logic [3:0] k, input logic [16:0] qm);
      logic [12:0] top;
      top = 13'h1fff >> (4'd8 - k);
      return {1'b0, top, qm, 23'd0, 1'b1};
   endfunction

   // BRAM model with 2-cycle read latency.
   always_ff @(posedge clk) begin
      r_d1         <= bram_word(pass_id, bram_rd_addr);
      bram_rd_data <= r_d1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_pass(input int p, input logic [3:0] k, input logic signed [11:0] sp,
                           input int rst_cyc, input int extra_start);
      logic [54:0] q;
      logic [63:0] fp, mg, ed;
      logic        n, o, exp_ovf, tail;
      int          limit, a;
      pass_id     = p;
      current_k   = k;
      scale_power = sp;
      q           = calc_q(k, q_m);
      exp_ovf     = 1'b0;
      limit       = (rst_cyc > 0) ? rst_cyc + 20 : N + 8;
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= limit; c++) begin
         @(negedge clk);
         start = 1'b0;
         rst   = 1'b0;
         tail  = (rst_cyc > 0) && (c > rst_cyc);
         check("wea", 64'(bram_wea), 64'(!tail && c >= 6 && c <= N + 5));
         if (!tail && c >= 6 && c <= N + 5) begin
            a = c - 6;
            tv(p, a % 16, fp, n, mg, o);
            if (o) exp_ovf = 1'b1;
            if (o) ed = 64'd0;
            else if (n && mg != 64'd0) ed = 64'(q) - mg;
            else ed = mg;
            check("wr_addr", 64'(bram_wr_addr), 64'(a));
            check("wr_data", 64'(bram_wr_data), ed);
            check("overflow", 64'(overflow), 64'(exp_ovf));
         end
         if (!tail && c <= N) check("rd_addr", 64'(bram_rd_addr), 64'(c - 1));
         if (c == 1) begin
            check("busy_start", 64'(busy), 64'd1);
            check("done_start", 64'(done), 64'd0);
            check("ovf_start", 64'(overflow), 64'd0);
         end
         if (rst_cyc <= 0 && c == N + 5) begin
            check("done_last_wr", 64'(done), 64'd0);
            check("busy_last_wr", 64'(busy), 64'd1);
         end
         if (rst_cyc <= 0 && c >= N + 6) begin
            check("done", 64'(done), 64'd1);
            check("busy_end", 64'(busy), 64'd0);
            check("ovf_end", 64'(overflow), 64'(exp_ovf));
            check("rd_addr_hold", 64'(bram_rd_addr), 64'(N - 1));
         end
         if (tail) begin
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_done", 64'(done), 64'd0);
            check("rst_ovf", 64'(overflow), 64'd0);
            check("rst_rd_addr", 64'(bram_rd_addr), 64'd0);
         end
         if (c == extra_start) start = 1'b1;
         if (c == rst_cyc) rst = 1'b1;
      end
   endtask

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      q_m         = 17'h0abcd;
      current_k   = 4'd8;
      scale_power = 12'sd0;
      pass_id     = 1;
      repeat (3) @(negedge clk);
      check("reset_wea", 64'(bram_wea), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_ovf", 64'(overflow), 64'd0);
      check("reset_rd_addr", 64'(bram_rd_addr), 64'd0);
      check("reset_wr_addr", 64'(bram_wr_addr), 64'd0);
      check("reset_wr_data", 64'(bram_wr_data), 64'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run_pass(1, 4'd8, 12'sd0, 0, 0);
      run_pass(2, 4'd5, 12'sd4, 0, 50);
      run_pass(3, 4'd8, -12'sd5, 100, 0);
      run_pass(3, 4'd8, -12'sd5, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
